// File: rtl/bt_radio_pkg.sv
// Shared constants for the bt_radio RF front-end model: channel widths, idle channel code,
// noise LFSR taps and default seed.
package bt_radio_pkg;

  localparam int FK_W_DEF   = 7;
  localparam int NUM_CH_DEF = 79;

  localparam logic [FK_W_DEF-1:0] FK_IDLE = 7'h7F;

  localparam int LFSR_W      = 15;
  localparam int LFSR_TAP_HI = 14;
  localparam int LFSR_TAP_LO = 13;

  localparam logic [LFSR_W-1:0] LFSR_SEED_DEF = 15'h7FFF;

endpackage

// File: rtl/bt_radio_lfsr.sv
// 15-bit Fibonacci noise generator (x^15+x^14+1); advances every cycle outside reset.
// Instantiated by bt_radio only when BT_RADIO_NOISE_EN is defined.
module bt_radio_lfsr
  import bt_radio_pkg::*;
#(
  parameter logic [LFSR_W-1:0] SEED = LFSR_SEED_DEF
) (
  input  logic clk_6M,
  input  logic rstz,
  output logic noise_bit
);

  logic [LFSR_W-1:0] lfsr;

  always_ff @(posedge clk_6M) begin
    if (rstz) begin
      lfsr <= SEED;
    end else begin
      lfsr <= {lfsr[LFSR_W-2:0], lfsr[LFSR_TAP_HI] ^ lfsr[LFSR_TAP_LO]};
    end
  end

  assign noise_bit = lfsr[LFSR_TAP_HI];

endmodule

// File: rtl/bt_radio.sv
// Bluetooth RF front-end model: synthesizer channel register, registered TX forwarding and
// channel-gated RX delivery. BT_RADIO_NOISE_EN fills mismatched RX slots with LFSR noise.
module bt_radio
  import bt_radio_pkg::*;
#(
  parameter int                FK_W      = FK_W_DEF,
  parameter int                NUM_CH    = NUM_CH_DEF,
  parameter logic [LFSR_W-1:0] LFSR_SEED = LFSR_SEED_DEF
) (
  input  logic            clk_6M,
  input  logic            rstz,
  input  logic            txbitin,
  input  logic            rxbitin,
  input  logic            txen,
  input  logic            rxen,
  input  logic [FK_W-1:0] lc_fk,
  input  logic [FK_W-1:0] rxfk,
  input  logic            loadfreq_p,
  output logic            txbitout,
  output logic            rxbitout,
  output logic [FK_W-1:0] txfk
);

  localparam logic [FK_W-1:0] IDLE_FK   = {FK_W{1'b1}};
  localparam logic [FK_W-1:0] NUM_CH_FK = FK_W'(NUM_CH);

  logic [FK_W-1:0] cur_fk;
  logic            cur_valid;
  logic            noise_bit;
  logic            rx_next;

`ifdef BT_RADIO_NOISE_EN
  bt_radio_lfsr #(.SEED(LFSR_SEED)) u_lfsr (
    .clk_6M    (clk_6M),
    .rstz      (rstz),
    .noise_bit (noise_bit)
  );
`else
  logic unused_seed;
  assign unused_seed = ^LFSR_SEED;
  assign noise_bit   = 1'b0;
`endif

  assign cur_valid = (cur_fk < NUM_CH_FK);

  // Half-duplex: an active TX window blanks the receiver.
  always_comb begin
    rx_next = 1'b0;
    if (rxen && !txen) begin
      if (cur_valid && (rxfk == cur_fk)) rx_next = rxbitin;
      else                               rx_next = noise_bit;
    end
  end

  // Output equations use cur_fk as it stood before any same-edge retune.
  always_ff @(posedge clk_6M) begin
    if (rstz) begin
      cur_fk   <= IDLE_FK;
      txbitout <= 1'b0;
      rxbitout <= 1'b0;
      txfk     <= IDLE_FK;
    end else begin
      if (loadfreq_p) cur_fk <= lc_fk;
      txbitout <= txen & txbitin;
      rxbitout <= rx_next;
      txfk     <= (txen && cur_valid) ? cur_fk : IDLE_FK;
    end
  end

endmodule

// File: tb/tb_bt_radio.sv
// Directed scoreboard bench for bt_radio; expected outputs come from a behavioural model of
// the radio and are queued when each input vector is driven, then checked after the edge.
module tb_bt_radio;
  import bt_radio_pkg::*;

  logic       clk_6M = 1'b0;
  logic       rstz, txbitin, rxbitin, txen, rxen, loadfreq_p;
  logic [6:0] lc_fk, rxfk;
  logic       txbitout, rxbitout;
  logic [6:0] txfk;

  typedef struct packed {
    logic       tx;
    logic       rx;
    logic [6:0] fk;
  } exp_t;

  exp_t        exp_q[$];
  int          vectors = 0;
  int          miscompares = 0;
  logic [6:0]  m_cur;
  logic [14:0] m_lfsr;

  bt_radio dut (
    .clk_6M     (clk_6M),
    .rstz       (rstz),
    .txbitin    (txbitin),
    .rxbitin    (rxbitin),
    .txen       (txen),
    .rxen       (rxen),
    .lc_fk      (lc_fk),
    .rxfk       (rxfk),
    .loadfreq_p (loadfreq_p),
    .txbitout   (txbitout),
    .rxbitout   (rxbitout),
    .txfk       (txfk)
  );

  always #5 clk_6M = ~clk_6M;

  task automatic chk(input string tag, input logic [6:0] obs, input logic [6:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  function automatic logic noise_of(input logic [14:0] l);
`ifdef BT_RADIO_NOISE_EN
    return l[14];
`else
    return 1'b0;
`endif
  endfunction

  task automatic step(input string tag, input logic rst, input logic tb, input logic te,
                      input logic re, input logic rb, input logic [6:0] lfk,
                      input logic [6:0] rfk, input logic ld);
    exp_t e, got;
    @(negedge clk_6M);
    rstz = rst; txbitin = tb; txen = te; rxen = re; rxbitin = rb;
    lc_fk = lfk; rxfk = rfk; loadfreq_p = ld;
    if (rst) begin
      e = '{tx: 1'b0, rx: 1'b0, fk: FK_IDLE};
      m_cur  = FK_IDLE;
      m_lfsr = LFSR_SEED_DEF;
    end else begin
      e.tx = te & tb;
      e.fk = (te && m_cur < 7'd79) ? m_cur : FK_IDLE;
      if (!re || te)                      e.rx = 1'b0;
      else if (rfk == m_cur && m_cur < 7'd79) e.rx = rb;
      else                                e.rx = noise_of(m_lfsr);
      if (ld) m_cur = lfk;
      m_lfsr = {m_lfsr[13:0], m_lfsr[14] ^ m_lfsr[13]};
    end
    exp_q.push_back(e);
    @(posedge clk_6M);
    #1;
    e = exp_q.pop_front();
    got = '{tx: txbitout, rx: rxbitout, fk: txfk};
    vectors++;
    assert (got === e) else begin
      miscompares++;
      $error("FAIL %s: observed tx=%b rx=%b fk=%0h expected tx=%b rx=%b fk=%0h",
             tag, got.tx, got.rx, got.fk, e.tx, e.rx, e.fk);
    end
  endtask

  initial begin
    logic [3:0] pat;
    rstz = 1'b1; txbitin = 0; rxbitin = 0; txen = 0; rxen = 0;
    lc_fk = '0; rxfk = '0; loadfreq_p = 0;
    m_cur = FK_IDLE; m_lfsr = LFSR_SEED_DEF;

    // 1. reset with random inputs, then idle
    for (int i = 0; i < 2; i++)
      step("reset", 1'b1, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
           7'($urandom), 7'($urandom), 1'($urandom));
    chk("reset_fk", txfk, 7'h7F);
    chk("reset_bits", {5'b0, txbitout, rxbitout}, 7'd0);
    for (int i = 0; i < 3; i++) step("idle", 0, 0, 0, 0, 0, 7'd0, 7'd0, 0);
    chk("idle_fk", txfk, 7'h7F);

    // 2. tune to 23 and transmit 1,0,1,1
    step("load23", 0, 0, 0, 0, 0, 7'd23, 7'h7F, 1);
    pat = 4'b1011;
    for (int i = 3; i >= 0; i--) begin
      step("tx23", 0, pat[i], 1, 0, 0, 7'd0, 7'h7F, 0);
      chk("tx23_fk", txfk, 7'd23);
      chk("tx23_bit", {6'b0, txbitout}, {6'b0, pat[i]});
    end
    step("tx_off", 0, 1, 0, 0, 0, 7'd0, 7'h7F, 0);
    chk("tx_off_fk", txfk, 7'h7F);

    // 3. matched RX on 40: 0,1,1,0
    step("load40", 0, 0, 0, 0, 0, 7'd40, 7'h7F, 1);
    pat = 4'b0110;
    for (int i = 3; i >= 0; i--) begin
      step("rx40", 0, 0, 0, 1, pat[i], 7'd0, 7'd40, 0);
      chk("rx40_bit", {6'b0, rxbitout}, {6'b0, pat[i]});
    end

    // 4. mismatched RX: noise stream or zero
    for (int i = 0; i < 16; i++)
      step("rx_mismatch", 0, 0, 0, 1, 1'(i), 7'd0, 7'd41, 0);

    // 5. invalid channel, then half-duplex on a matched channel
    step("load100_tx", 0, 1, 1, 0, 0, 7'd100, 7'h7F, 1);
    chk("load100_tx_fk", txfk, 7'd40);
    step("tx100", 0, 1, 1, 0, 0, 7'd0, 7'h7F, 0);
    chk("tx100_fk", txfk, 7'h7F);
    for (int i = 0; i < 4; i++) begin
      step("rx100", 0, 0, 0, 1, 1, 7'd0, 7'd100, 0);
`ifndef BT_RADIO_NOISE_EN
      chk("rx100_zero", {6'b0, rxbitout}, 7'd0);
`endif
    end
    step("load40b", 0, 0, 0, 0, 0, 7'd40, 7'h7F, 1);
    for (int i = 0; i < 4; i++) begin
      step("half_duplex", 0, 1'(i), 1, 1, 1, 7'd0, 7'd40, 0);
      chk("half_duplex_rx", {6'b0, rxbitout}, 7'd0);
      chk("half_duplex_tx", {6'b0, txbitout}, {6'b0, 1'(i)});
    end

    // 6. retune during TX
    step("load5", 0, 0, 0, 0, 0, 7'd5, 7'h7F, 1);
    step("tx5", 0, 1, 1, 0, 0, 7'd0, 7'h7F, 0);
    step("retune60", 0, 0, 1, 0, 0, 7'd60, 7'h7F, 1);
    chk("retune_n1", txfk, 7'd5);
    step("tx60", 0, 1, 1, 0, 0, 7'd0, 7'h7F, 0);
    chk("retune_n2", txfk, 7'd60);

    // 7. reset mid-packet: channel is lost until reloaded
    step("rst_mid", 1, 1, 1, 1, 1, 7'd0, 7'd60, 0);
    chk("rst_mid_fk", txfk, 7'h7F);
    step("tx_after_rst", 0, 1, 1, 0, 0, 7'd0, 7'h7F, 0);
    chk("tx_after_rst_fk", txfk, 7'h7F);
    step("rx_after_rst", 0, 0, 0, 1, 1, 7'd0, 7'd60, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/bt_radio.md
Name: bt_radio

Overview:
Behavioural-synthesizable Bluetooth RF front-end model sitting between a baseband link controller (lc) and a peer radio instance in two-device simulations.
- Tunes a synthesizer channel register from the LC's next-channel index on a load strobe.
- Forwards TX bits with the tuned channel to the air side.
- Delivers air-side bits to the LC only when the receiver is enabled and tuned to the peer's transmit channel; otherwise delivers noise or zero.

Parameters:
- FK_W, 7, channel index width.
- NUM_CH, 79, valid channels 0..NUM_CH-1.
- LFSR_SEED, 15'h7FFF, noise LFSR reset value; must be nonzero.

Ports:
- clk_6M  in  1  6 MHz system clock; all logic on rising edge.
- rstz  in  1  reset. Despite the legacy name, it is synchronous and active-high: rstz=1 at a rising edge resets.
- txbitin  in  1  LC transmit bit.
- rxbitin  in  1  air-side bit from the peer radio's txbitout.
- txen  in  1  transmit window.
- rxen  in  1  receive window.
- lc_fk  in  FK_W  next channel from the LC.
- rxfk  in  FK_W  peer radio's txfk (air channel).
- loadfreq_p  in  1  one-cycle strobe: load lc_fk into the synthesizer.
- txbitout  out  1  air-side transmit bit.
- rxbitout  out  1  bit delivered to the LC receiver.
- txfk  out  FK_W  channel currently radiated; FK_IDLE when silent.

Behaviour:
- Constant FK_IDLE = all-ones (7'h7F). A channel is valid iff it is < NUM_CH.
- cur_fk register:
  - Reset value is FK_IDLE.
  - Loaded with lc_fk on a cycle with loadfreq_p=1; otherwise holds.
  - The new value is usable from the next cycle.
  - lc_fk >= NUM_CH is loaded as-is but treated as invalid.
- All outputs are registered, latency 1 cycle. For inputs sampled at edge n, outputs at n+1:
  - txbitout = txen ? txbitin : 0.
  - txfk = (txen && cur_fk valid) ? cur_fk : FK_IDLE.
  - rxbitout:
    - 0 if !rxen or txen (half-duplex; TX wins when both are high).
    - rxbitin if rxen && rxfk==cur_fk && cur_fk valid.
    - Otherwise noise bit (see Optional Feature).
- cur_fk used in the equations above is the value before any same-cycle loadfreq_p update. A strobe coinciding with txen therefore affects txfk one cycle later.
- Noise LFSR:
  - 15-bit Fibonacci, polynomial x^15+x^14+1, shift left, feedback = bit14 ^ bit13 into bit0.
  - Advances every cycle while not in reset.
  - Noise bit = bit14.
- Reset values: txbitout=0, rxbitout=0, txfk=FK_IDLE, cur_fk=FK_IDLE, lfsr=LFSR_SEED.
- Reset mid-packet: outputs go to reset values at the next edge; the channel must be reloaded via loadfreq_p.
- rxbitin/rxfk are not checked for X. A silent peer drives FK_IDLE, which never matches a valid cur_fk.
- No internal timers; PLL settling is the LC's responsibility.

Optional Feature:
- Macro BT_RADIO_NOISE_EN.
- Defined: mismatched/invalid-channel receive slots output the LFSR noise bit.
- Undefined: those slots output 0, and the LFSR logic is omitted.

Decomposition:
- Package bt_radio_pkg: FK_W, NUM_CH, FK_IDLE, LFSR polynomial taps, default seed.
- One sub-module, bt_radio_lfsr: 15-bit noise generator with clk_6M, rstz, seed parameter, and output bit. It is instantiated only under BT_RADIO_NOISE_EN.

Test Plan:
1. Reset: hold rstz=1 two cycles with random inputs -> txbitout=0, rxbitout=0, txfk=7'h7F; after release with txen=0 and rxen=0, outputs stay 0/7'h7F.
2. Tune and TX: loadfreq_p with lc_fk=7'd23, next cycle txen=1 with txbitin pattern 1,0,1,1 -> txfk=7'd23 and txbitout=1,0,1,1, each delayed one cycle; txen=0 -> txfk=7'h7F the next cycle.
3. Matched RX: cur_fk=7'd40, rxen=1, rxfk=7'd40, rxbitin=0,1,1,0 -> rxbitout=0,1,1,0, delayed one cycle.
4. Mismatched RX: cur_fk=7'd40, rxfk=7'd41, rxen=1 -> with BT_RADIO_NOISE_EN, rxbitout equals the reference LFSR bit14 stream from seed 7FFF; without it, rxbitout=0 constantly.
5. Invalid channel and half-duplex:
   - lc_fk=7'd100 loaded with txen=1 -> txfk=7'h7F; rxfk=7'd100 with rxen=1 -> no passthrough.
   - txen=1 and rxen=1 on a matched channel -> rxbitout=0, txbitout follows txbitin.
6. Retune during TX: txen=1 on ch 5, loadfreq_p with lc_fk=7'd60 at cycle n -> txfk=5 at n+1, 60 at n+2.
